// File: rtl/mcs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcs_pkg
//  Description : Shared types for the multimode count/shift register:
//                operation-mode enum and burst FSM state constants.
//  Revision    : 1.0  initial release
// ============================================================================
package mcs_pkg;

    // Operation applied to the register at a clock edge
    typedef enum logic [2:0] {
        MODE_HOLD   = 3'b000,
        MODE_COUNT  = 3'b001,
        MODE_SHIFT  = 3'b010,
        MODE_ROTATE = 3'b011,
        MODE_ASHIFT = 3'b100,
        MODE_LOAD   = 3'b101,
        MODE_PRESET = 3'b110,
        MODE_CLEAR  = 3'b111
    } mode_e;

    // Burst sequencer state encoding
    typedef logic [1:0] mcs_state_t;
    localparam mcs_state_t ST_IDLE = 2'd0;
    localparam mcs_state_t ST_RUN  = 2'd1;
    localparam mcs_state_t ST_DONE = 2'd2;

endpackage : mcs_pkg
`default_nettype wire

// File: rtl/mcs_op_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mcs_op_unit
//  Description : Combinational next-value and carry/borrow computation for
//                the multimode register. Pure function of its inputs.
//  Ports       : count_i     current register value
//                mode_i      operation select
//                direction_i 0 = up/left, 1 = down/right
//                step_i      count magnitude (zero-extended)
//                load_val_i  parallel load data
//                next_o      value the register takes if the op is applied
//                carry_o     carry-out (up) or borrow (down) of COUNT
//  Config      : MCS_SATURATE_EN - COUNT clamps instead of wrapping
//  Revision    : 1.0  initial release
// ============================================================================
module mcs_op_unit
    import mcs_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter int               STEP_W     = 4,
    parameter logic [15:0]      PRESET_VAL = 16'h1382
) (
    input  logic [WIDTH-1:0]    count_i,
    input  mode_e               mode_i,
    input  logic                direction_i,
    input  logic [STEP_W-1:0]   step_i,
    input  logic [WIDTH-1:0]    load_val_i,
    output logic [WIDTH-1:0]    next_o,
    output logic                carry_o
);

    // Padding on the left makes PRESET_VAL either truncate or zero-extend
    // to WIDTH with one slice, whichever way WIDTH compares to 16.
    localparam logic [WIDTH+15:0] c_preset_ext = {{WIDTH{1'b0}}, PRESET_VAL};
    localparam logic [WIDTH-1:0]  c_preset     = c_preset_ext[WIDTH-1:0];

    // One extra bit above the register catches carry-out / borrow.
    logic [WIDTH:0] w_step_ext;
    logic [WIDTH:0] w_sum_up;
    logic [WIDTH:0] w_sum_dn;

    assign w_step_ext = {{(WIDTH+1-STEP_W){1'b0}}, step_i};
    assign w_sum_up   = {1'b0, count_i} + w_step_ext;
    assign w_sum_dn   = {1'b0, count_i} - w_step_ext;

    always_comb begin
        next_o  = count_i;
        carry_o = 1'b0;
        case (mode_i)
            MODE_HOLD: begin
                next_o = count_i;
            end
            MODE_COUNT: begin
                if (!direction_i) begin
                    carry_o = w_sum_up[WIDTH];
`ifdef MCS_SATURATE_EN
                    next_o  = w_sum_up[WIDTH] ? {WIDTH{1'b1}} : w_sum_up[WIDTH-1:0];
`else
                    next_o  = w_sum_up[WIDTH-1:0];
`endif
                end else begin
                    carry_o = w_sum_dn[WIDTH];
`ifdef MCS_SATURATE_EN
                    next_o  = w_sum_dn[WIDTH] ? {WIDTH{1'b0}} : w_sum_dn[WIDTH-1:0];
`else
                    next_o  = w_sum_dn[WIDTH-1:0];
`endif
                end
            end
            MODE_SHIFT: begin
                next_o = direction_i ? {1'b0, count_i[WIDTH-1:1]}
                                     : {count_i[WIDTH-2:0], 1'b0};
            end
            MODE_ROTATE: begin
                next_o = direction_i ? {count_i[0], count_i[WIDTH-1:1]}
                                     : {count_i[WIDTH-2:0], count_i[WIDTH-1]};
            end
            MODE_ASHIFT: begin
                // Left arithmetic shift is the same as a logical left shift
                next_o = direction_i ? {count_i[WIDTH-1], count_i[WIDTH-1:1]}
                                     : {count_i[WIDTH-2:0], 1'b0};
            end
            MODE_LOAD: begin
                next_o = load_val_i;
            end
            MODE_PRESET: begin
                next_o = c_preset;
            end
            MODE_CLEAR: begin
                next_o = {WIDTH{1'b0}};
            end
            default: begin
                next_o = count_i;
            end
        endcase
    end

endmodule : mcs_op_unit
`default_nettype wire

// File: rtl/multimode_count_shift.sv
`default_nettype none
// ============================================================================
//  Module      : multimode_count_shift
//  Description : General-purpose WIDTH-bit datapath register with eight
//                operation modes. Ops run one per cycle while enable is high,
//                or as a self-timed burst of burst_len ops launched by start.
//  Ports       : clock        rising-edge clock
//                reset        asynchronous, active-low
//                enable       level, one live op per cycle while idle
//                start        pulse, launch a burst while idle
//                burst_len    number of ops in a burst (0 = done only)
//                mode         operation select
//                direction    0 = up/left, 1 = down/right
//                step         count magnitude
//                load_val     parallel load data
//                clear_flags  clear sticky overflow
//                count        register value
//                busy         burst in progress
//                done         one-cycle burst completion pulse
//                overflow     sticky carry/borrow flag
//                zero         count == 0 (combinational)
//  Config      : MCS_SATURATE_EN - COUNT saturates instead of wrapping
//  Revision    : 1.0  initial release
// ============================================================================
module multimode_count_shift
    import mcs_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter int               STEP_W     = 4,
    parameter int               BURST_W    = 4,
    parameter logic [15:0]      PRESET_VAL = 16'h1382
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                start,
    input  logic [BURST_W-1:0]  burst_len,
    input  logic [2:0]          mode,
    input  logic                direction,
    input  logic [STEP_W-1:0]   step,
    input  logic [WIDTH-1:0]    load_val,
    input  logic                clear_flags,
    output logic [WIDTH-1:0]    count,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic                zero
);

    mcs_state_t          state_q,        state_d;
    logic [WIDTH-1:0]    count_q,        count_d;
    logic [BURST_W-1:0]  remaining_q,    remaining_d;
    mode_e               shadow_mode_q,  shadow_mode_d;
    logic                shadow_dir_q,   shadow_dir_d;
    logic [STEP_W-1:0]   shadow_step_q,  shadow_step_d;
    logic                overflow_q,     overflow_d;
    logic                busy_q;
    logic                done_q;

    logic                op_apply;
    mode_e               op_mode;
    logic                op_dir;
    logic [STEP_W-1:0]   op_step;
    logic [WIDTH-1:0]    op_next;
    logic                op_carry;

    // During a burst the captured op drives the unit; live inputs otherwise.
    assign op_mode = (state_q == ST_RUN) ? shadow_mode_q : mode_e'(mode);
    assign op_dir  = (state_q == ST_RUN) ? shadow_dir_q  : direction;
    assign op_step = (state_q == ST_RUN) ? shadow_step_q : step;

    mcs_op_unit #(
        .WIDTH      (WIDTH),
        .STEP_W     (STEP_W),
        .PRESET_VAL (PRESET_VAL)
    ) u_op_unit (
        .count_i     (count_q),
        .mode_i      (op_mode),
        .direction_i (op_dir),
        .step_i      (op_step),
        .load_val_i  (load_val),
        .next_o      (op_next),
        .carry_o     (op_carry)
    );

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        shadow_mode_d = shadow_mode_q;
        shadow_dir_d  = shadow_dir_q;
        shadow_step_d = shadow_step_q;
        op_apply      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // start outranks enable; a zero-length burst only pulses done
                if (start) begin
                    if (burst_len != '0) begin
                        shadow_mode_d = mode_e'(mode);
                        shadow_dir_d  = direction;
                        shadow_step_d = step;
                        remaining_d   = burst_len;
                        state_d       = ST_RUN;
                    end else begin
                        state_d       = ST_DONE;
                    end
                end else if (enable) begin
                    op_apply = 1'b1;
                end
            end
            ST_RUN: begin
                op_apply    = 1'b1;
                remaining_d = remaining_q - BURST_W'(1);
                if (remaining_q == BURST_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        count_d = op_apply ? op_next : count_q;

        // A new carry/borrow beats a simultaneous clear request
        if (op_apply && op_carry) begin
            overflow_d = 1'b1;
        end else if (clear_flags) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            remaining_q   <= '0;
            shadow_mode_q <= MODE_HOLD;
            shadow_dir_q  <= 1'b0;
            shadow_step_q <= '0;
            overflow_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            remaining_q   <= remaining_d;
            shadow_mode_q <= shadow_mode_d;
            shadow_dir_q  <= shadow_dir_d;
            shadow_step_q <= shadow_step_d;
            overflow_q    <= overflow_d;
            busy_q        <= (state_d == ST_RUN);
            // done follows the DONE state by one cycle, so it appears one
            // cycle after the final count update of the burst
            done_q        <= (state_q == ST_DONE);
        end
    end

    assign count    = count_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign zero     = (count_q == '0);

endmodule : multimode_count_shift
`default_nettype wire

// File: tb/tb_multimode_count_shift.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multimode_count_shift
//  Description : Directed self-checking bench for multimode_count_shift with
//                a cycle-level reference model and pinned literal checks.
//  Config      : MCS_SATURATE_EN - expectations follow saturating COUNT
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multimode_count_shift;

    localparam int WIDTH   = 16;
    localparam int STEP_W  = 4;
    localparam int BURST_W = 4;
`ifdef MCS_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam longint FULL = longint'(1) << WIDTH;
    localparam longint HALF = FULL >> 1;

    logic                clock;
    logic                reset;
    logic                enable;
    logic                start;
    logic [BURST_W-1:0]  burst_len;
    logic [2:0]          mode;
    logic                direction;
    logic [STEP_W-1:0]   step;
    logic [WIDTH-1:0]    load_val;
    logic                clear_flags;
    logic [WIDTH-1:0]    count;
    logic                busy;
    logic                done;
    logic                overflow;
    logic                zero;

    int n_checks = 0;
    int n_fail   = 0;

    multimode_count_shift #(
        .WIDTH      (WIDTH),
        .STEP_W     (STEP_W),
        .BURST_W    (BURST_W),
        .PRESET_VAL (16'h1382)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .start       (start),
        .burst_len   (burst_len),
        .mode        (mode),
        .direction   (direction),
        .step        (step),
        .load_val    (load_val),
        .clear_flags (clear_flags),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .zero        (zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (arithmetic, not bit slices) --------
    longint m_count;
    bit     m_ovf;
    bit     m_busy;
    bit     m_done;
    int     m_ops_left;
    bit     m_done_pending;
    int     m_sh_mode;
    bit     m_sh_dir;
    longint m_sh_step;

    function automatic longint op_value(input longint c, input int md, input bit dir,
                                        input longint st, input longint lv,
                                        output bit carry);
        longint t;
        carry = 1'b0;
        t = c;
        case (md)
            1: begin
                if (!dir) begin
                    t = c + st;
                    if (t >= FULL) begin
                        carry = 1'b1;
                        t = SAT ? FULL - 1 : t - FULL;
                    end
                end else begin
                    t = c - st;
                    if (t < 0) begin
                        carry = 1'b1;
                        t = SAT ? 0 : t + FULL;
                    end
                end
            end
            2: t = dir ? c / 2 : (c * 2) % FULL;
            3: t = dir ? c / 2 + (c % 2) * HALF : (c * 2) % FULL + c / HALF;
            4: t = dir ? c / 2 + ((c >= HALF) ? HALF : 0) : (c * 2) % FULL;
            5: t = lv % FULL;
            6: t = longint'(16'h1382) % FULL;
            7: t = 0;
            default: t = c;
        endcase
        return t;
    endfunction

    always @(posedge clock) begin
        bit carry;
        bit applied;
        carry   = 1'b0;
        applied = 1'b0;
        if (!reset) begin
            m_count        = 0;
            m_ovf          = 1'b0;
            m_ops_left     = 0;
            m_done_pending = 1'b0;
            m_done         = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_done_pending) begin
                m_done_pending = 1'b0;
                m_done         = 1'b1;
            end else if (m_ops_left > 0) begin
                m_count = op_value(m_count, m_sh_mode, m_sh_dir, m_sh_step, longint'(load_val), carry);
                applied = 1'b1;
                m_ops_left--;
                if (m_ops_left == 0) m_done_pending = 1'b1;
            end else if (start) begin
                if (burst_len != 0) begin
                    m_sh_mode  = int'(mode);
                    m_sh_dir   = direction;
                    m_sh_step  = longint'(step);
                    m_ops_left = int'(burst_len);
                end else begin
                    m_done_pending = 1'b1;
                end
            end else if (enable) begin
                m_count = op_value(m_count, int'(mode), direction, longint'(step), longint'(load_val), carry);
                applied = 1'b1;
            end
            if (applied && carry)  m_ovf = 1'b1;
            else if (clear_flags)  m_ovf = 1'b0;
        end
        m_busy = (m_ops_left > 0);
        #1;
        chk("cmp_count",    64'(count),    64'(m_count));
        chk("cmp_busy",     64'(busy),     64'(m_busy));
        chk("cmp_done",     64'(done),     64'(m_done));
        chk("cmp_overflow", 64'(overflow), 64'(m_ovf));
        chk("cmp_zero",     64'(zero),     64'(m_count == 0));
    end

    // ---------------- directed stimulus ----------------------------------
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic live_op(input logic [2:0] md, input logic dir);
        mode = md; direction = dir; enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; start = 1'b0; burst_len = '0; mode = 3'd0;
        direction = 1'b0; step = '0; load_val = '0; clear_flags = 1'b0;
        tick();
        tick();
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_busy",  64'(busy),  64'h0);
        chk("rst_done",  64'(done),  64'h0);
        chk("rst_ovf",   64'(overflow), 64'h0);
        chk("rst_zero",  64'(zero),  64'h1);
        reset = 1'b1;
        tick();

        // COUNT up across the top
        load_val = 16'hFFFE; live_op(3'd5, 1'b0);
        step = 4'd3;          live_op(3'd1, 1'b0);
        chk("pin_count_up_wrap", 64'(count), SAT ? 64'hFFFF : 64'h0001);
        chk("pin_count_up_ovf",  64'(overflow), 64'h1);
        clear_flags = 1'b1; tick(); clear_flags = 1'b0;
        chk("pin_clear_ovf", 64'(overflow), 64'h0);

        // rotate / arithmetic / logical shifts
        load_val = 16'h0001; live_op(3'd5, 1'b0);
        live_op(3'd3, 1'b1);
        chk("pin_rotate_r", 64'(count), 64'h8000);
        live_op(3'd4, 1'b1);
        live_op(3'd4, 1'b1);
        chk("pin_ashift_r", 64'(count), 64'hE000);
        live_op(3'd2, 1'b1);
        chk("pin_shift_r", 64'(count), 64'h7000);
        live_op(3'd3, 1'b0);
        chk("pin_rotate_l", 64'(count), 64'hE000);

        // burst of 4 SHIFT left with enable held high
        load_val = 16'h0001; live_op(3'd5, 1'b0);
        start = 1'b1; burst_len = 4'd4; mode = 3'd2; direction = 1'b0; enable = 1'b1;
        tick();
        start = 1'b0; mode = 3'd7;      // live CLEAR must be ignored
        chk("pin_burst_busy0", 64'(busy), 64'h1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("pin_burst_count", 64'(count), 64'(longint'(1) << i));
            chk("pin_burst_busy",  64'(busy),  64'(i < 4));
            chk("pin_burst_done",  64'(done),  64'h0);
        end
        tick();
        chk("pin_burst_done_pulse", 64'(done), 64'h1);
        chk("pin_burst_hold",       64'(count), 64'h0010);
        enable = 1'b0;
        tick();
        chk("pin_burst_done_end", 64'(done), 64'h0);

        // zero-length burst
        start = 1'b1; burst_len = 4'd0;
        tick();
        start = 1'b0;
        chk("pin_len0_busy", 64'(busy), 64'h0);
        tick();
        chk("pin_len0_done",  64'(done),  64'h1);
        chk("pin_len0_count", 64'(count), 64'h0010);
        tick();

        // PRESET and CLEAR
        live_op(3'd6, 1'b0);
        chk("pin_preset", 64'(count), 64'h1382);
        chk("pin_preset_zero", 64'(zero), 64'h0);
        live_op(3'd7, 1'b0);
        chk("pin_clear_zero", 64'(zero), 64'h1);

        // COUNT down from 0 with clear in the same cycle: set wins
        step = 4'd1; clear_flags = 1'b1;
        live_op(3'd1, 1'b1);
        chk("pin_count_dn", 64'(count), SAT ? 64'h0000 : 64'hFFFF);
        chk("pin_set_wins", 64'(overflow), 64'h1);
        tick();
        clear_flags = 1'b0;
        chk("pin_clear_only", 64'(overflow), 64'h0);

        // burst aborted by reset
        load_val = 16'h0000; live_op(3'd5, 1'b0);
        start = 1'b1; burst_len = 4'd8; mode = 3'd1; direction = 1'b0; step = 4'd2;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("pin_abort_pre", 64'(count), 64'h0006);
        reset = 1'b0;
        #1;
        chk("pin_abort_count", 64'(count), 64'h0);
        chk("pin_abort_busy",  64'(busy),  64'h0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("pin_abort_nodone", 64'(done), 64'h0);

        // fresh burst after reset
        start = 1'b1; burst_len = 4'd2; mode = 3'd1; direction = 1'b0; step = 4'd5;
        tick();
        start = 1'b0;
        chk("pin_relaunch_busy", 64'(busy), 64'h1);
        tick(); tick();
        chk("pin_relaunch_count", 64'(count), 64'h000A);
        tick();
        chk("pin_relaunch_done", 64'(done), 64'h1);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_multimode_count_shift
`default_nettype wire
